// File: rtl/jk_sync_counter.sv
// -----------------------------------------------------------------------------
// jk_sync_counter
//
// Synchronous up/down counter built from per-bit JK stages. Each register bit
// follows q[i]+ = (j[i] & ~q[i]) | (~k[i] & q[i]); the J/K drives are computed
// combinationally from the requested operation and exported for observation.
//
// Operation priority per edge: load, then count (en), then hold.
//   load : q <= min(d, MAX); J/K steer each bit straight to the target value.
//   count: q steps up/down by one inside 0..MAX, wrapping at the ends and
//          setting the sticky ovf flag. J = K = bits that must toggle.
//   hold : J = K = 0.
//
// Build option (macro JKC_SATURATE_EN):
//   defined   -> an up step at MAX holds MAX and a down step at 0 holds 0;
//                the saturated step drives J = K = 0 and still sets ovf.
//   undefined -> wrap-around behaviour (default).
//
// Parameters:
//   WIDTH    counter width in bits (default 4)
//   MAX      highest count value, 1 <= MAX <= 2**WIDTH-1 (default 9)
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset (q = 0, ovf = 0)
//   en       count enable
//   up       direction: 1 = up, 0 = down
//   load     synchronous parallel load request
//   d        load value (clamped to MAX)
//   clr_ovf  synchronous clear of ovf (a simultaneous wrap wins)
//   q        registered count
//   j_vec    per-bit J drive for the next edge (combinational)
//   k_vec    per-bit K drive for the next edge (combinational)
//   tc       terminal count: en & ~load & at the end of the current direction
//   ovf      sticky wrap/overflow flag (registered)
// -----------------------------------------------------------------------------
module jk_sync_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    logic [WIDTH-1:0] d_eff;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] q_d;
    logic             at_top;
    logic             at_bot;
    logic             above_max;
    logic             step_ovf;
    logic             set_ovf;
    logic             ovf_d;

    // Count step target. A value above MAX can only appear if MAX is changed
    // underneath a loaded value; it is steered back into range (up -> 0 with
    // ovf, down -> MAX).
    always_comb begin
        at_top    = (q == MAX_Q);
        at_bot    = (q == '0);
        above_max = (q > MAX_Q);
        cnt_next  = q;
        step_ovf  = 1'b0;
        if (up) begin
            if (above_max) begin
                cnt_next = '0;
                step_ovf = 1'b1;
            end else if (at_top) begin
`ifdef JKC_SATURATE_EN
                cnt_next = q;
`else
                cnt_next = '0;
`endif
                step_ovf = 1'b1;
            end else begin
                cnt_next = q + ONE_Q;
            end
        end else begin
            if (above_max) begin
                cnt_next = MAX_Q;
            end else if (at_bot) begin
`ifdef JKC_SATURATE_EN
                cnt_next = q;
`else
                cnt_next = MAX_Q;
`endif
                step_ovf = 1'b1;
            end else begin
                cnt_next = q - ONE_Q;
            end
        end
    end

    // J/K drive selection and next-state evaluation through the JK equation.
    always_comb begin
        d_eff   = (d > MAX_Q) ? MAX_Q : d;
        j_vec   = '0;
        k_vec   = '0;
        set_ovf = 1'b0;
        if (load) begin
            j_vec = d_eff & ~q;
            k_vec = ~d_eff & q;
        end else if (en) begin
            // A saturated step has cnt_next == q, so J = K = 0 falls out here.
            j_vec   = q ^ cnt_next;
            k_vec   = q ^ cnt_next;
            set_ovf = step_ovf;
        end
        tc    = en & ~load & ((up & at_top) | (~up & at_bot));
        q_d   = (j_vec & ~q) | (~k_vec & q);
        ovf_d = set_ovf | (ovf & ~clr_ovf);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= q_d;
            ovf <= ovf_d;
        end
    end

endmodule

// File: tb/tb_jk_sync_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_sync_counter
//
// Directed scenarios followed by randomized operations on jk_sync_counter
// (WIDTH=4, MAX=9). Expected values come from an integer reference model of
// the counting rules. Honors JKC_SATURATE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_jk_sync_counter;

    localparam int W = 4;
    localparam int M = 9;

    logic         clk;
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] d;
    logic         clr_ovf;
    logic [W-1:0] q;
    logic [W-1:0] j_vec;
    logic [W-1:0] k_vec;
    logic         tc;
    logic         ovf;

    int checks;
    int errors;
    int mq;
    bit movf;

    jk_sync_counter #(.WIDTH(W), .MAX(M)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up      (up),
        .load    (load),
        .d       (d),
        .clr_ovf (clr_ovf),
        .q       (q),
        .j_vec   (j_vec),
        .k_vec   (k_vec),
        .tc      (tc),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation: drive inputs at the falling edge, check the combinational
    // drives before the rising edge, then check registered state afterwards.
    task automatic step(input string tag, input logic e, input logic u, input logic l,
                        input logic [W-1:0] dv, input logic c);
        int n;
        bit set;
        logic [W-1:0] qv, nv, ej, ek;
        bit etc;
        en = e; up = u; load = l; d = dv; clr_ovf = c;
        set = 1'b0;
        if (l) begin
            n = (int'(dv) > M) ? M : int'(dv);
        end else if (e) begin
            if (u) begin
                if (mq > M)       begin n = 0; set = 1'b1; end
                else if (mq == M) begin
`ifdef JKC_SATURATE_EN
                    n = M;
`else
                    n = 0;
`endif
                    set = 1'b1;
                end else n = mq + 1;
            end else begin
                if (mq > M)       n = M;
                else if (mq == 0) begin
`ifdef JKC_SATURATE_EN
                    n = 0;
`else
                    n = M;
`endif
                    set = 1'b1;
                end else n = mq - 1;
            end
        end else begin
            n = mq;
        end
        qv = W'(mq);
        nv = W'(n);
        if (l) begin
            ej = nv & ~qv;
            ek = ~nv & qv;
        end else begin
            ej = qv ^ nv;
            ek = qv ^ nv;
        end
        etc = e && !l && ((u && mq == M) || (!u && mq == 0));
        #1;
        chk({tag, ":j"},  j_vec, ej);
        chk({tag, ":k"},  k_vec, ek);
        chk({tag, ":tc"}, tc, etc);
        @(posedge clk);
        mq   = n;
        movf = set || (movf && !c);
        @(negedge clk);
        chk({tag, ":q"},   q, mq);
        chk({tag, ":ovf"}, ovf, movf);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = '0; clr_ovf = 1'b0;
        mq = 0; movf = 1'b0;
        #1;
        chk("rst_q", q, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Down wrap from 0: J = K = 1001 before the edge, q = 9, ovf = 1.
        step("load0", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        step("dnwrap", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
`ifndef JKC_SATURATE_EN
        chk("dnwrap_q_const", q, 9);
`endif
        chk("dnwrap_ovf_const", ovf, 1);

        // Reset mid-count while high-phase of clk, q previously 5.
        step("load5", 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        en = 1'b1; up = 1'b1; load = 1'b0;
        @(posedge clk);
        mq = 6;
        #2 reset = 1'b0;
        #1;
        mq = 0; movf = 1'b0;
        chk("arst_q", q, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        reset = 1'b1;
        step("rel_up", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("rel_up_const", q, 1);

        // Reset during a load: the load must not land while reset is low.
        load = 1'b1; d = 4'd7; en = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mq = 0;
        chk("arst_load_q", q, 0);
        reset = 1'b1;

        // Load priority with clamp: q=3, d=12 -> j=1000, k=0010, q=9.
        step("load3", 1'b0, 1'b0, 1'b1, 4'd3, 1'b1);
        step("ldprio", 1'b1, 1'b1, 1'b1, 4'd12, 1'b0);
        chk("ldprio_q_const", q, 9);

        // Up sequence from 0 over 10 edges.
        step("load0b", 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
        for (int i = 0; i < 10; i++) step("upseq", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // Flag race: clr on the wrap edge keeps ovf, clr on the next clears.
        step("load9", 1'b0, 1'b0, 1'b1, 4'd9, 1'b1);
        step("race_set", 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("race_set_const", ovf, 1);
        step("race_clr", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("race_clr_const", ovf, 0);

        // Hold at 6 for three edges.
        step("load6", 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("hold_q_const", q, 6);

        // Direction change while enabled takes effect on the same edge.
        step("dir_up", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step("dir_dn", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0),
                 W'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_sync_counter.md
JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MAX, default 9: highest count value; legal range 1 <= MAX <= 2^WIDTH-1.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port en, input, 1: count enable.
REQ-006 Port up, input, 1: direction; 1 counts up, 0 counts down.
REQ-007 Port load, input, 1: synchronous parallel load request.
REQ-008 Port d, input, WIDTH: load value.
REQ-009 Port clr_ovf, input, 1: synchronous clear of the ovf flag.
REQ-010 Port q, output, WIDTH: registered count.
REQ-011 Port j_vec, output, WIDTH: per-bit J drive for the next edge, combinational.
REQ-012 Port k_vec, output, WIDTH: per-bit K drive for the next edge, combinational.
REQ-013 Port tc, output, 1: terminal-count indication, combinational.
REQ-014 Port ovf, output, 1: sticky wrap/overflow flag, registered.

Function
REQ-015 Each bit of q SHALL be a JK stage: q[i]+ = (j_vec[i] & ~q[i]) | (~k_vec[i] & q[i]).
REQ-016 Input priority per edge SHALL be: load, then en, then hold.
REQ-017 Load: the effective value d_eff SHALL be d when d <= MAX, else MAX.
REQ-018 Load: the block SHALL drive j_vec = d_eff & ~q and k_vec = ~d_eff & q, and ignore en and up.
REQ-019 Count: j_vec and k_vec SHALL both equal q ^ q_next, where q_next is the value after the count step.
REQ-020 Hold (load=0, en=0): j_vec and k_vec SHALL both be 0, and q SHALL be unchanged.
REQ-021 Up step: q+1 when q < MAX; when q == MAX, wrap to 0 and set ovf.
REQ-022 Down step: q-1 when q > 0; when q == 0, wrap to MAX and set ovf.
REQ-023 If a load leaves q > MAX, the block SHALL unreachable-guard it: the next up step goes to 0 with ovf set, and the next down step goes to MAX.
REQ-024 tc SHALL be en & ~load & ((up & q==MAX) | (~up & q==0)).
REQ-025 Latency: q, ovf and the tc change caused by a q update SHALL appear one edge after the inputs are sampled.
REQ-026 When clr_ovf is asserted, ovf SHALL clear on the next edge.
REQ-027 When clr_ovf coincides with a wrap event, the set SHALL win and ovf SHALL stay 1.
REQ-028 When up changes while en=1, the new direction SHALL take effect on the same edge.

Reset
REQ-029 While reset=0, q SHALL be 0 and ovf SHALL be 0 immediately, independent of clk.
REQ-030 Deassertion of reset SHALL release the counter; the first state change happens on the next rising clk edge.
REQ-031 Reset asserted mid-count or during load SHALL abort the operation and leave no partial update.

Configuration
REQ-032 The block SHALL use the macro JKC_SATURATE_EN.
REQ-033 With JKC_SATURATE_EN defined, an up step at MAX SHALL hold MAX.
REQ-034 With JKC_SATURATE_EN defined, a down step at 0 SHALL hold 0.
REQ-035 With JKC_SATURATE_EN defined, every saturated step SHALL drive j_vec = k_vec = 0 and still set ovf; tc is unchanged.
REQ-036 Without JKC_SATURATE_EN, wrap SHALL follow REQ-021 and REQ-022.

Verification
REQ-037 Reset: reset=0 with q previously 5, mid-clock -> q=0 and ovf=0 immediately; after release with en=1, up=1 -> q=1 after one edge.
REQ-038 Up wrap: MAX=9, count up from 0 over 10 edges -> q sequence 1..9,0; tc=1 while q=9; ovf=1 after the wrap. With saturate: q stays 9.
REQ-039 Down wrap: load 0, then up=0, en=1 -> q=9, ovf=1, j_vec=k_vec=4'b1001 before the edge.
REQ-040 Load priority: q=3, load=1, en=1, d=12 -> q=9; j_vec=4'b1000 and k_vec=4'b0010 before the edge.
REQ-041 Flag race: clr_ovf=1 on the same edge as a 9->0 wrap -> ovf=1; clr_ovf=1 on the next edge, no wrap -> ovf=0.
REQ-042 Hold: en=0, load=0 for 3 edges at q=6 -> q=6, j_vec=k_vec=0, tc=0.
